// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game pacing logic: state encoding,
// index width and default pacing constants.
package genius_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHOW    = 2'd1,
        ST_GAP     = 2'd2,
        ST_WAIT_IN = 2'd3
    } state_e;

    localparam int IDX_W = 4;

    localparam int DEF_TICK_DIV      = 50_000_000;
    localparam int DEF_ON_TICKS      = 2;
    localparam int DEF_OFF_TICKS     = 1;
    localparam int DEF_TIMEOUT_TICKS = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// a synchronous clear restarts the count so the owner can align phases.
module tick_prescaler #(
    parameter int TICK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count;

    // NOTE: tick is decoded from the registered count, so it is glitch-free
    // and high for exactly one cycle per period.
    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/genius_pacer.sv
// Playback / answer-window pacer for the Genius game.
// Define GENIUS_PACER_TIMEOUT_EN to build the WAIT_IN state and timeout path.
module genius_pacer
    import genius_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int ON_TICKS      = DEF_ON_TICKS,
    parameter int OFF_TICKS     = DEF_OFF_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             play,
    input  logic [IDX_W-1:0] level,
    input  logic             rx_arm,
    input  logic             rx_ack,
    input  logic             rx_done,
    output logic [IDX_W-1:0] seq_idx,
    output logic             seq_show,
    output logic             busy,
    output logic             play_done,
    output logic             timeout
);

    localparam int TC_W = $clog2(max3(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS) + 1);

    state_e           state;
    logic [IDX_W-1:0] level_q;
    logic [TC_W-1:0]  tick_cnt;
    logic [TC_W-1:0]  tick_limit;
    logic             tick;
    logic             phase_end;
    logic             win_restart;
    logic             presc_clr;

`ifdef GENIUS_PACER_TIMEOUT_EN
    logic timeout_q;
    assign timeout     = timeout_q;
    assign win_restart = (state == ST_WAIT_IN) && (rx_ack || rx_done);
`else
    logic unused_rx;
    assign unused_rx   = ^{rx_arm, rx_ack, rx_done};
    assign timeout     = 1'b0;
    assign win_restart = 1'b0;
`endif

    // Phase length is selected by state; any state change restarts the timebase.
    always_comb begin
        tick_limit = TC_W'(TIMEOUT_TICKS - 1);
        case (state)
            ST_SHOW: tick_limit = TC_W'(ON_TICKS - 1);
            ST_GAP:  tick_limit = TC_W'(OFF_TICKS - 1);
            default: ;
        endcase
        phase_end = tick && (tick_cnt == tick_limit);
        presc_clr = (state == ST_IDLE) || phase_end || win_restart;
    end

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .clear(presc_clr),
        .tick (tick)
    );

    // NOTE: all state and outputs update with <= so every register sees the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            level_q   <= '0;
            seq_idx   <= '0;
            seq_show  <= 1'b0;
            busy      <= 1'b0;
            play_done <= 1'b0;
            tick_cnt  <= '0;
`ifdef GENIUS_PACER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            play_done <= 1'b0;
`ifdef GENIUS_PACER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (presc_clr) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + TC_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (play) begin
                        level_q  <= level;
                        seq_idx  <= '0;
                        seq_show <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SHOW;
`ifdef GENIUS_PACER_TIMEOUT_EN
                    end else if (rx_arm) begin
                        busy  <= 1'b1;
                        state <= ST_WAIT_IN;
`endif
                    end
                end
                ST_SHOW: begin
                    if (phase_end) begin
                        seq_show <= 1'b0;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        if (seq_idx == level_q) begin
                            busy      <= 1'b0;
                            play_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            seq_idx  <= seq_idx + IDX_W'(1);
                            seq_show <= 1'b1;
                            state    <= ST_SHOW;
                        end
                    end
                end
                ST_WAIT_IN: begin
`ifdef GENIUS_PACER_TIMEOUT_EN
                    // rx_ack only restarts the timebase via presc_clr.
                    if (rx_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!rx_ack && phase_end) begin
                        busy      <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_genius_pacer.sv
// Scoreboard bench for genius_pacer: per-cycle stimulus and expected outputs
// are queued together, then replayed and compared one clock at a time.
module tb_genius_pacer;

    localparam int TD  = 2;
    localparam int ON  = 2;
    localparam int OFF = 1;
    localparam int TMO = 3;
    localparam int PH  = (ON + OFF) * TD;
    localparam int SL  = ON * TD;

    logic       clock = 1'b0;
    logic       reset;
    logic       play, rx_arm, rx_ack, rx_done;
    logic [3:0] level;
    logic [3:0] seq_idx;
    logic       seq_show, busy, play_done, timeout;
    logic [7:0] obs;

    int         vectors     = 0;
    int         miscompares = 0;
    int         last_idx    = 0;
    int         cyc;
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] e;

    assign obs = {seq_idx, seq_show, busy, play_done, timeout};

    genius_pacer #(
        .TICK_DIV     (TD),
        .ON_TICKS     (ON),
        .OFF_TICKS    (OFF),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .play     (play),
        .level    (level),
        .rx_arm   (rx_arm),
        .rx_ack   (rx_ack),
        .rx_done  (rx_done),
        .seq_idx  (seq_idx),
        .seq_show (seq_show),
        .busy     (busy),
        .play_done(play_done),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    // Closed-form playback expectation for cycle c after play sampled at edge 0.
    function automatic logic [7:0] pb(input int c, input int lvl);
        int len;
        len = (lvl + 1) * PH;
        if (c <= len)
            return {4'((c - 1) / PH), ((c - 1) % PH) < SL, 1'b1, 1'b0, 1'b0};
        return {4'(lvl), 1'b0, 1'b0, (c == len + 1), 1'b0};
    endfunction

    // Stimulus vector layout: {level[3:0], play, rx_arm, rx_ack, rx_done}
    task automatic test_reset();
        reset = 1'b0; play = 1'b0; rx_arm = 1'b0; rx_ack = 1'b0; rx_done = 1'b0;
        level = 4'd0;
        @(posedge clock); #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: obs %b exp %b", obs, 8'h00);
        end
        play = 1'b1; level = 4'd5;
        @(posedge clock); #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_holds_play: obs %b exp %b", obs, 8'h00);
        end
        play = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release_idle: obs %b exp %b", obs, 8'h00);
        end
    endtask

    // level=2; a second play, an rx_arm and a level change mid-run are ignored.
    task automatic test_playback();
        for (int i = 0; i < 20; i++) begin
            stim_q.push_back({(i < 3) ? 4'd2 : 4'd9, i == 0 || i == 8, i == 10, 1'b0, 1'b0});
            exp_q.push_back(pb(i + 1, 2));
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL playback c%0d: obs %b exp %b (idx,show,busy,done,tmo)", cyc, obs, e);
            end
        end
        last_idx = 2;
    endtask

    task automatic test_play_priority();
        for (int i = 0; i < 20; i++) begin
            stim_q.push_back({4'd1, i == 0, i == 0, 1'b0, 1'b0});
            exp_q.push_back(pb(i + 1, 1));
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL play_priority c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
        last_idx = 1;
    endtask

`ifdef GENIUS_PACER_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 0; i < 12; i++) begin
            stim_q.push_back({4'd0, 1'b0, i == 0, 1'b0, 1'b0});
            exp_q.push_back({4'(last_idx), 1'b0, (i + 1) <= 6, (i + 1) == 7 ? 2'b01 : 2'b00});
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL timeout c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
    endtask

    // Four windows: ack restart, early done, done on the expiring edge,
    // ack on the expiring edge.
    task automatic test_ack_done();
        int  c;
        logic bsy, tmo;
        for (int i = 0; i < 45; i++) begin
            c   = i + 1;
            bsy = (c >= 1 && c <= 11) || (c >= 13 && c <= 15) ||
                  (c >= 23 && c <= 28) || (c >= 31 && c <= 42);
            tmo = (c == 12) || (c == 43);
            stim_q.push_back({4'd0, 1'b0, i == 0 || i == 12 || i == 22 || i == 30,
                              i == 5 || i == 36, i == 15 || i == 28});
            exp_q.push_back({4'(last_idx), 1'b0, bsy, 1'b0, tmo});
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL ack_done c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
    endtask
`else
    task automatic test_disabled();
        for (int i = 0; i < 22; i++) begin
            stim_q.push_back({4'd0, 1'b0, i < 20, i == 5, 1'b0});
            exp_q.push_back({4'(last_idx), 4'b0000});
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL disabled_window c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
    endtask
`endif

    task automatic test_max_level();
        for (int i = 0; i < 98; i++) begin
            stim_q.push_back({4'd15, i == 0, 1'b0, 1'b0, 1'b0});
            exp_q.push_back(pb(i + 1, 15));
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL max_level c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
        last_idx = 15;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            stim_q.push_back({4'd3, i == 0, 1'b0, 1'b0, 1'b0});
            exp_q.push_back(pb(i + 1, 3));
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL pre_reset_show c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset_immediate: obs %b exp %b", obs, 8'h00);
        end
        @(posedge clock); #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset_held: obs %b exp %b", obs, 8'h00);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stim_q.push_back({4'd0, i == 0, 1'b0, 1'b0, 1'b0});
            exp_q.push_back(pb(i + 1, 0));
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            {level, play, rx_arm, rx_ack, rx_done} = stim_q.pop_front();
            @(posedge clock); #1; cyc++;
            e = exp_q.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL post_reset_play c%0d: obs %b exp %b", cyc, obs, e);
            end
        end
        last_idx = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_playback();
        test_play_priority();
`ifdef GENIUS_PACER_TIMEOUT_EN
        test_timeout();
        test_ack_done();
`else
        test_disabled();
`endif
        test_max_level();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/genius_pacer.md
# genius_pacer

Playback and input-window pacer for the Genius game. It sits beside the top-level game FSM and the sequence generator. During the show phase it steps the sequence index and gates the digit display at a human-visible rate. During the answer phase it runs an inactivity timeout. The game FSM only issues `play` / `rx_arm` and waits for `play_done` / `timeout`, instead of advancing one element per system clock.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: system clocks per pacing tick (≥2).
- `ON_TICKS`, 2: ticks a symbol is displayed (≥1).
- `OFF_TICKS`, 1: blank ticks after each symbol (≥1).
- `TIMEOUT_TICKS`, 10: ticks without a button before `timeout` (≥1).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `play`  in  1  start playback; sampled only in IDLE.
- `level`  in  4  last index to show; `level+1` elements; captured at `play`.
- `rx_arm`  in  1  open answer window; sampled only in IDLE.
- `rx_ack`  in  1  valid button accepted; restarts timeout.
- `rx_done`  in  1  answer window finished; closes without `timeout`.
- `seq_idx`  out  4  index requested from sequence generator.
- `seq_show`  out  1  display gate; 1 = show symbol on digit 0.
- `busy`  out  1  state ≠ IDLE.
- `play_done`  out  1  one-cycle pulse, playback finished.
- `timeout`  out  1  one-cycle pulse, answer window expired.

## Operation
- States: IDLE, SHOW, GAP, WAIT_IN. All outputs are registered.
- Reset (async, any state): IDLE, `seq_idx`=0, `seq_show`=0, `busy`=0, pulses 0, all counters 0, captured level 0.
- Prescaler: counts 0..TICK_DIV-1. `tick` asserts at TICK_DIV-1. The prescaler and the tick counter clear on every state change, so every phase has an exact length.
- IDLE:
  - `play`=1: capture `level`, `seq_idx`←0, go to SHOW.
  - Else `rx_arm`=1: go to WAIT_IN.
  - `play` has priority over simultaneous `rx_arm`.
- SHOW: `seq_show`=1. After ON_TICKS ticks, go to GAP.
- GAP: `seq_show`=0. After OFF_TICKS ticks:
  - If `seq_idx`==captured level: go to IDLE and pulse `play_done`. `seq_idx` holds its value.
  - Else `seq_idx`+1 and go to SHOW.
- WAIT_IN, evaluated in this priority order:
  - `rx_done`: go to IDLE, no pulse.
  - `rx_ack`: clear the prescaler and tick counter.
  - Tick counter reaching TIMEOUT_TICKS: go to IDLE and pulse `timeout`.
  - `rx_done` wins over a simultaneous timeout. `rx_ack` in the expiring cycle cancels the expiry.
- `play`, `rx_arm` while busy: ignored, no effect.
- `level` changes mid-playback: ignored.
- `seq_idx` is 4-bit. Captured level ≤15 bounds it, so it never wraps.

## Timing
- Phase length = ticks × TICK_DIV clocks.
- `play` sampled at edge 0 → SHOW from cycle 1. `seq_show` high cycles 1..ON_TICKS·TICK_DIV.
- Full playback occupies (level+1)·(ON_TICKS+OFF_TICKS)·TICK_DIV cycles. `play_done` is high in the first IDLE cycle after that.
- `timeout` is high the cycle after the last prescaler count of tick TIMEOUT_TICKS, i.e. TIMEOUT_TICKS·TICK_DIV+1 cycles after arming or after the last `rx_ack`.
- `busy` rises the cycle after an accepted `play`/`rx_arm`. It falls together with the `play_done`/`timeout` pulse.

## Configuration
- `GENIUS_PACER_TIMEOUT_EN` defined: WAIT_IN state and the timeout path are present as specified.
- Undefined:
  - WAIT_IN is not built.
  - `rx_arm`, `rx_ack`, `rx_done` are ignored.
  - `timeout` is tied 0.
  - The answer window is unbounded; the game FSM owns it.

## Structure
- Shared package `genius_pkg` holds:
  - the 2-bit state encoding: IDLE=0, SHOW=1, GAP=2, WAIT_IN=3;
  - the 4-bit level/index width constant;
  - default pacing constants.
- One sub-module, `tick_prescaler`: parameter TICK_DIV, with a synchronous clear input and a one-cycle `tick` output. The FSM and tick counter stay in `genius_pacer`.

## Test plan
All scenarios use TICK_DIV=2, ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=3.
- `play` pulse, `level`=2 → `seq_idx` 0,1,2. `seq_show` high cycles 1–4, 7–10, 13–16, low cycles 5–6, 11–12, 17–18. `play_done` high cycle 19 only.
- `play` and `rx_arm` in the same cycle in IDLE → playback runs. `timeout` never asserts.
- `rx_arm`, no `rx_ack` → `timeout` pulse 7 cycles after arming. `busy` low afterwards.
- `rx_arm`, `rx_ack` at cycle 5 → `timeout` at cycle 12. `rx_done` before expiry → no `timeout`, IDLE.
- `reset` low in mid-SHOW (asynchronous, not on an edge) → outputs zero immediately. After release a new `play` with `level`=0 gives one 6-cycle playback.
- `GENIUS_PACER_TIMEOUT_EN` undefined, `rx_arm` held 20 cycles → `busy`=0 and `timeout`=0 throughout.
